// File: rtl/calc_pkg.sv
// Shared types for the calculator sequencer: FSM states, key classes and operator codes.
package calc_pkg;

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, RESULT, ERROR} state_t;

  typedef enum logic [2:0] {K_NONE, K_CLR, K_EQ, K_OP, K_DIG} key_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  // Priority clr > eq > op > digit; digits above 9 decode to nothing.
  function automatic key_t key_class(input logic v, c, e, o, input logic [3:0] d);
    if (!v) return K_NONE;
    if (c) return K_CLR;
    if (e) return K_EQ;
    if (o) return K_OP;
    if (d <= 4'd9) return K_DIG;
    return K_NONE;
  endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// Decimal operand accumulator: acc*10+d with digit-count and width overflow rejection.
module calc_digit_accum #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5,
  parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             add,
  input  logic [3:0]       d,
  output logic [WIDTH-1:0] acc,
  output logic [CW-1:0]    count
);

  localparam logic [WIDTH+3:0] TEN = (WIDTH + 4)'(10);

  logic [WIDTH+3:0] ext;
  logic             ok;

  // Four extra bits hold any acc*10+9, so the top nibble flags overflow.
  assign ext = {4'b0, acc} * TEN + (WIDTH + 4)'(d);
  assign ok  = (count != CW'(MAX_DIGITS)) && (ext[WIDTH+3:WIDTH] == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (clr) begin
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= WIDTH'(d);
      count <= CW'(1);
    end else if (add && ok) begin
      acc   <= ext[WIDTH-1:0];
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: keypad events -> operands -> ALU handshake -> display.
// Optional chained operations are enabled by defining CALC_CHAIN_EN.
module calc_sequencer import calc_pkg::*; #(
  parameter int WIDTH       = 16,
  parameter int OP_W        = 3,
  parameter int MAX_DIGITS  = 5,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic             key_is_clr,
  input  logic             key_is_eq,
  input  logic             key_is_op,
  input  logic [OP_W-1:0]  key_op,
  input  logic [3:0]       key_digit,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [OP_W-1:0]  op_sel,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic             alu_err,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] display_val,
  output logic             result_valid,
  output logic             error,
  output logic             busy
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'((ALU_TIMEOUT > 0) ? ALU_TIMEOUT - 1 : 0);

  state_t            state, state_d;
  key_t              kc;
  logic [WIDTH-1:0]  acc, res, opa_d, opb_d, res_d;
  logic [CW-1:0]     count;
  logic [OP_W-1:0]   pend, opsel_d, pend_d;
  logic              chain, chain_d, start_d;
  logic [TW-1:0]     tcnt, tcnt_d;
  logic              acc_clr, acc_load, acc_add;

  assign kc = key_class(key_valid, key_is_clr, key_is_eq, key_is_op, key_digit);

  calc_digit_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_accum (
    .clk(clk), .rst_n(rst_n), .clr(acc_clr), .load(acc_load), .add(acc_add),
    .d(key_digit), .acc(acc), .count(count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      operand_a <= '0;
      operand_b <= '0;
      op_sel    <= '0;
      res       <= '0;
      pend      <= '0;
      chain     <= 1'b0;
      tcnt      <= '0;
      alu_start <= 1'b0;
    end else begin
      state     <= state_d;
      operand_a <= opa_d;
      operand_b <= opb_d;
      op_sel    <= opsel_d;
      res       <= res_d;
      pend      <= pend_d;
      chain     <= chain_d;
      tcnt      <= tcnt_d;
      alu_start <= start_d;
    end
  end

  always_comb begin
    state_d  = state;
    opa_d    = operand_a;
    opb_d    = operand_b;
    opsel_d  = op_sel;
    res_d    = res;
    pend_d   = pend;
    chain_d  = chain;
    tcnt_d   = tcnt;
    start_d  = 1'b0;
    acc_clr  = 1'b0;
    acc_load = 1'b0;
    acc_add  = 1'b0;
    if (kc == K_CLR) begin
      state_d = IDLE;
      opa_d   = '0;
      opb_d   = '0;
      opsel_d = '0;
      res_d   = '0;
      pend_d  = '0;
      chain_d = 1'b0;
      tcnt_d  = '0;
      acc_clr = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (kc == K_DIG) begin
            acc_load = 1'b1;
            state_d  = GET_A;
          end else if (kc == K_OP) begin
            opa_d   = '0;
            opsel_d = key_op;
            acc_clr = 1'b1;
            state_d = GET_B;
          end
        end
        GET_A: begin
          if (kc == K_DIG) acc_add = 1'b1;
          else if (kc == K_OP) begin
            opa_d   = acc;
            opsel_d = key_op;
            acc_clr = 1'b1;
            state_d = GET_B;
          end else if (kc == K_EQ) begin
            res_d   = acc;
            state_d = RESULT;
          end
        end
        GET_B: begin
          if (kc == K_DIG) acc_add = 1'b1;
          else if (kc == K_OP) begin
            if (count == '0) opsel_d = key_op;
`ifdef CALC_CHAIN_EN
            else begin
              opb_d   = acc;
              pend_d  = key_op;
              chain_d = 1'b1;
              acc_clr = 1'b1;
              tcnt_d  = '0;
              start_d = 1'b1;
              state_d = EXEC;
            end
`endif
          end else if (kc == K_EQ && count != '0) begin
            opb_d   = acc;
            chain_d = 1'b0;
            acc_clr = 1'b1;
            tcnt_d  = '0;
            start_d = 1'b1;
            state_d = EXEC;
          end
        end
        EXEC: begin
          if (alu_done) begin
            if (alu_err) state_d = ERROR;
            else begin
              res_d = alu_result;
              if (chain) begin
                opa_d   = alu_result;
                opsel_d = pend;
                chain_d = 1'b0;
                state_d = GET_B;
              end else state_d = RESULT;
            end
          end else if (ALU_TIMEOUT != 0 && tcnt == TMAX) state_d = ERROR;
          else tcnt_d = tcnt + TW'(1);
        end
        RESULT: begin
          if (kc == K_DIG) begin
            acc_load = 1'b1;
            state_d  = GET_A;
          end else if (kc == K_OP) begin
            opa_d   = res;
            opsel_d = key_op;
            acc_clr = 1'b1;
            state_d = GET_B;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    display_val = '0;
    case (state)
      IDLE, GET_A: display_val = acc;
      GET_B:       display_val = (count != '0) ? acc : operand_a;
      EXEC:        display_val = operand_b;
      RESULT:      display_val = res;
      default:     display_val = '0;
    endcase
  end

  assign result_valid = (state == RESULT);
  assign error        = (state == ERROR);
  assign busy         = (state == EXEC);

endmodule
